// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
// Pure declarations; no logic, no latency, no flow control.
package rr_arb_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arb_pick.sv
// Round-robin pick: lowest valid index above last_grant, else lowest valid overall.
// Combinational, zero latency; no flow control of its own.
module rr_arb_pick
  import rr_arb_pkg::*;
#(
  parameter  int N_IN = 4,
  localparam int CW   = clog2(N_IN)
) (
  input  logic [N_IN-1:0] valid,
  input  logic [CW-1:0]   last_grant,
  output logic [CW-1:0]   chosen,
  output logic            any_valid
);

  // Second loop runs last so a valid index above last_grant overrides the wrap-around pick.
  always_comb begin
    chosen = CW'(N_IN - 1);
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (valid[i]) chosen = CW'(i);
    end
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (valid[i] && (CW'(i) > last_grant)) chosen = CW'(i);
    end
  end

  assign any_valid = |valid;

endmodule

// File: rtl/rr_lock_arbiter.sv
// N_IN-to-1 round-robin arbiter holding a grant across multi-beat packets until the last beat.
// Zero latency, or one registered stage with RR_LOCK_ARBITER_OUT_REG_EN; only the chosen channel sees ready.
module rr_lock_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int N_IN = 4,
  parameter  int W    = 8,
  localparam int CW   = clog2(N_IN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IN-1:0]   io_in_valid,
  output logic [N_IN-1:0]   io_in_ready,
  input  logic [N_IN*W-1:0] io_in_bits,
  input  logic [N_IN-1:0]   io_in_last,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [W-1:0]      io_out_bits,
  output logic              io_out_last,
  output logic [CW-1:0]     io_chosen
);

  logic [CW-1:0] last_grant_q, last_grant_d;
  logic [CW-1:0] lock_idx_q, lock_idx_d;
  arb_state_t    state_q, state_d;

  logic [CW-1:0] pick_chosen;
  logic          pick_any;
  logic [CW-1:0] sel;
  logic          arb_valid;
  logic [W-1:0]  arb_bits;
  logic          arb_last;
  logic          int_ready;
  logic          fire;

  rr_arb_pick #(.N_IN(N_IN)) u_pick (
    .valid      (io_in_valid),
    .last_grant (last_grant_q),
    .chosen     (pick_chosen),
    .any_valid  (pick_any)
  );

  always_comb begin
    sel       = (state_q == ARB_LOCKED) ? lock_idx_q : pick_chosen;
    arb_valid = (state_q == ARB_LOCKED) ? io_in_valid[lock_idx_q] : pick_any;
    arb_bits  = '0;
    arb_last  = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (sel == CW'(i)) begin
        arb_bits = io_in_bits[i*W +: W];
        arb_last = io_in_last[i];
      end
    end
  end

  always_comb begin
    io_in_ready = '0;
    for (int i = 0; i < N_IN; i++) begin
      io_in_ready[i] = int_ready && (sel == CW'(i));
    end
  end

  assign fire = arb_valid && int_ready;

  always_comb begin
    last_grant_d = last_grant_q;
    lock_idx_d   = lock_idx_q;
    state_d      = state_q;
    if (fire) begin
      last_grant_d = sel;
      if (state_q == ARB_IDLE) begin
        if (!arb_last) begin
          state_d    = ARB_LOCKED;
          lock_idx_d = sel;
        end
      end else if (arb_last) begin
        state_d = ARB_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= '0;
      lock_idx_q   <= '0;
      state_q      <= ARB_IDLE;
    end else begin
      last_grant_q <= last_grant_d;
      lock_idx_q   <= lock_idx_d;
      state_q      <= state_d;
    end
  end

`ifdef RR_LOCK_ARBITER_OUT_REG_EN
  logic          out_vld_q, out_vld_d;
  logic [W-1:0]  out_bits_q, out_bits_d;
  logic          out_last_q, out_last_d;
  logic [CW-1:0] out_chosen_q, out_chosen_d;

  // Register accepts whenever it is empty or draining, so throughput stays at one beat per cycle.
  assign int_ready = !out_vld_q || io_out_ready;

  always_comb begin
    out_vld_d    = out_vld_q;
    out_bits_d   = out_bits_q;
    out_last_d   = out_last_q;
    out_chosen_d = out_chosen_q;
    if (int_ready) begin
      out_vld_d = arb_valid;
      if (fire) begin
        out_bits_d   = arb_bits;
        out_last_d   = arb_last;
        out_chosen_d = sel;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld_q    <= 1'b0;
      out_bits_q   <= '0;
      out_last_q   <= 1'b0;
      out_chosen_q <= '0;
    end else begin
      out_vld_q    <= out_vld_d;
      out_bits_q   <= out_bits_d;
      out_last_q   <= out_last_d;
      out_chosen_q <= out_chosen_d;
    end
  end

  assign io_out_valid = out_vld_q;
  assign io_out_bits  = out_bits_q;
  assign io_out_last  = out_last_q;
  assign io_chosen    = out_chosen_q;
`else
  assign int_ready    = io_out_ready;
  assign io_out_valid = arb_valid;
  assign io_out_bits  = arb_bits;
  assign io_out_last  = arb_last;
  assign io_chosen    = sel;
`endif

endmodule
